// File: rtl/bsg_manycore_edge_bridge_pkg.sv
// Shared definitions for the manycore edge bridge.
//   ret_type_e / ret_ack_k : return packet type field (low 2 bits)
//   *_width_f              : derived widths of mesh and return packets
package bsg_manycore_edge_bridge_pkg;

    typedef enum logic [1:0] {
        RET_NONE  = 2'b00,
        RET_ACK   = 2'b01,
        RET_RSVD2 = 2'b10,
        RET_RSVD3 = 2'b11
    } ret_type_e;

    localparam logic [1:0] ret_ack_k = RET_ACK;

    // {orig, src_y, src_x}
    function automatic int packet_width_f(int orig_w, int x_w, int y_w);
        return orig_w + x_w + y_w;
    endfunction

    // {dst_y, dst_x, type}
    function automatic int ret_packet_width_f(int x_w, int y_w);
        return x_w + y_w + 2;
    endfunction

    function automatic int cnt_width_f(int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bsg_manycore_edge_bridge_fifo.sv
// bsg_fifo_1r1w_small: small circular-buffer FIFO, registered occupancy.
//   v_i/ready_o/data_i : push side (push = v_i & ready_o)
//   v_o/data_o/yumi_i  : pop side (yumi_i only when v_o)
// ready_o depends only on stored occupancy, so a pop never frees a slot
// for a push in the same cycle (no fall-through, no bypass).
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];
    logic [ptr_w_lp-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                push, pop;

    assign ready_o = (count_q != cnt_w_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rd_q];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            mem_d[wr_q] = data_i;
            wr_d = (wr_q == ptr_w_lp'(els_p - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop)
            rd_d = (rd_q == ptr_w_lp'(els_p - 1)) ? '0 : rd_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bsg_manycore_edge_bridge.sv
// bsg_manycore_edge_bridge: boundary bridge for one mesh edge port.
//   ext_*    : external packets without source coordinates
//   link_*   : mesh packets {orig, src_y, src_x}
//   ret_*_o  : returns generated for each egress packet delivered externally
//   ret_*_i  : returns from the mesh; each one releases an ingress credit
//   credits_o: outstanding ingress packets; error_o: sticky protocol error
// stub_p=1 ties every output to 0 and instantiates nothing.
module bsg_manycore_edge_bridge
    import bsg_manycore_edge_bridge_pkg::*;
#(
    // coordinate/packet widths have no meaningful default; set them per instance
    parameter int x_cord_width_p      = 2,
    parameter int y_cord_width_p      = 3,
    parameter int orig_packet_width_p = 16,
    parameter int in_fifo_els_p       = 2,
    parameter int out_fifo_els_p      = 2,
    parameter int ret_fifo_els_p      = 2,
    parameter int max_credits_p       = 8,
    parameter int stub_p              = 0
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_i,
    input  logic [x_cord_width_p-1:0]                             my_x_i,
    input  logic [y_cord_width_p-1:0]                             my_y_i,
    input  logic [orig_packet_width_p-1:0]                        ext_data_i,
    input  logic                                                  ext_v_i,
    output logic                                                  ext_ready_o,
    output logic [orig_packet_width_p-1:0]                        ext_data_o,
    output logic                                                  ext_v_o,
    input  logic                                                  ext_ready_i,
    output logic [orig_packet_width_p+x_cord_width_p+y_cord_width_p-1:0] link_data_o,
    output logic                                                  link_v_o,
    input  logic                                                  link_ready_i,
    input  logic [orig_packet_width_p+x_cord_width_p+y_cord_width_p-1:0] link_data_i,
    input  logic                                                  link_v_i,
    output logic                                                  link_ready_o,
    output logic [x_cord_width_p+y_cord_width_p+1:0]              ret_data_o,
    output logic                                                  ret_v_o,
    input  logic                                                  ret_ready_i,
    input  logic [x_cord_width_p+y_cord_width_p+1:0]              ret_data_i,
    input  logic                                                  ret_v_i,
    output logic                                                  ret_ready_o,
    output logic [$clog2(max_credits_p+1)-1:0]                    credits_o,
    output logic                                                  error_o
);
    localparam int packet_width_lp     = packet_width_f(orig_packet_width_p, x_cord_width_p, y_cord_width_p);
    localparam int ret_packet_width_lp = ret_packet_width_f(x_cord_width_p, y_cord_width_p);
    localparam int cord_w_lp           = x_cord_width_p + y_cord_width_p;
    localparam int credit_w_lp         = cnt_width_f(max_credits_p);

    typedef struct packed {
        logic [y_cord_width_p-1:0] y;
        logic [x_cord_width_p-1:0] x;
        logic [1:0]                typ;
    } ret_pkt_s;

    if (stub_p != 0) begin : g_stub
        assign ext_ready_o  = 1'b0;
        assign ext_data_o   = '0;
        assign ext_v_o      = 1'b0;
        assign link_data_o  = '0;
        assign link_v_o     = 1'b0;
        assign link_ready_o = 1'b0;
        assign ret_data_o   = '0;
        assign ret_v_o      = 1'b0;
        assign ret_ready_o  = 1'b0;
        assign credits_o    = '0;
        assign error_o      = 1'b0;
    end else begin : g_bridge
        logic                       in_v, in_yumi;
        logic                       out_v, ext_xfer, ret_space;
        logic [packet_width_lp-1:0] out_data;
        ret_pkt_s                   ret_push, ret_in;
        logic                       inc, dec, unused_ret_bits;
        logic [credit_w_lp-1:0]     credits_q, credits_d;
        logic                       error_q, error_d;

        // ---- ingress: ext -> mesh, source coordinates appended at push ----
        bsg_fifo_1r1w_small #(.width_p(packet_width_lp), .els_p(in_fifo_els_p)) in_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .v_i     (ext_v_i),
            .ready_o (ext_ready_o),
            .data_i  ({ext_data_i, my_y_i, my_x_i}),
            .v_o     (in_v),
            .data_o  (link_data_o),
            .yumi_i  (in_yumi)
        );

        assign link_v_o = in_v & (credits_q < credit_w_lp'(max_credits_p));
        assign in_yumi  = link_v_o & link_ready_i;

        // ---- egress: mesh -> ext, one return per delivered packet ----
        bsg_fifo_1r1w_small #(.width_p(packet_width_lp), .els_p(out_fifo_els_p)) out_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .v_i     (link_v_i),
            .ready_o (link_ready_o),
            .data_i  (link_data_i),
            .v_o     (out_v),
            .data_o  (out_data),
            .yumi_i  (ext_xfer)
        );

        // Delivery is held off while the return FIFO is full, so every
        // delivered packet is guaranteed a return slot.
        assign ext_v_o    = out_v & ret_space;
        assign ext_xfer   = ext_v_o & ext_ready_i;
        assign ext_data_o = out_data[packet_width_lp-1:cord_w_lp];

        assign ret_push.y   = out_data[cord_w_lp-1:x_cord_width_p];
        assign ret_push.x   = out_data[x_cord_width_p-1:0];
        assign ret_push.typ = ret_ack_k;

        bsg_fifo_1r1w_small #(.width_p(ret_packet_width_lp), .els_p(ret_fifo_els_p)) ret_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .v_i     (ext_xfer),
            .ready_o (ret_space),
            .data_i  (ret_push),
            .v_o     (ret_v_o),
            .data_o  (ret_data_o),
            .yumi_i  (ret_v_o & ret_ready_i)
        );

        // ---- incoming returns: credit release + protocol check ----
        assign ret_ready_o     = ~reset_i;
        assign ret_in          = ret_data_i;
        assign unused_ret_bits = ^{ret_in.y, ret_in.x};
        assign inc             = in_yumi;
        assign dec             = ret_v_i & ret_ready_o;

        always_comb begin
            credits_d = credits_q;
            error_d   = error_q;
            if (dec && (ret_in.typ != ret_ack_k))
                error_d = 1'b1;
            if (inc && !dec)
                credits_d = credits_q + 1'b1;
            else if (dec && !inc) begin
                if (credits_q == '0)
                    error_d = 1'b1;   // return with nothing outstanding
                else
                    credits_d = credits_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                credits_q <= '0;
                error_q   <= 1'b0;
            end else begin
                credits_q <= credits_d;
                error_q   <= error_d;
            end
        end

        assign credits_o = credits_q;
        assign error_o   = error_q;
    end

endmodule

// File: tb/tb_bsg_manycore_edge_bridge.sv
module tb_bsg_manycore_edge_bridge;
    localparam int X = 2, Y = 3, O = 16, PW = 21, RW = 7, CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- bridge under test ----
    logic          reset_i;
    logic [X-1:0]  my_x_i;
    logic [Y-1:0]  my_y_i;
    logic [O-1:0]  ext_data_i, ext_data_o;
    logic          ext_v_i, ext_ready_o, ext_v_o, ext_ready_i;
    logic [PW-1:0] link_data_o, link_data_i;
    logic          link_v_o, link_ready_i, link_v_i, link_ready_o;
    logic [RW-1:0] ret_data_o, ret_data_i;
    logic          ret_v_o, ret_ready_i, ret_v_i, ret_ready_o;
    logic [CW-1:0] credits_o;
    logic          error_o;

    bsg_manycore_edge_bridge #(
        .x_cord_width_p(X), .y_cord_width_p(Y), .orig_packet_width_p(O),
        .in_fifo_els_p(2), .out_fifo_els_p(2), .ret_fifo_els_p(2),
        .max_credits_p(2), .stub_p(0)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
        .ext_data_i(ext_data_i), .ext_v_i(ext_v_i), .ext_ready_o(ext_ready_o),
        .ext_data_o(ext_data_o), .ext_v_o(ext_v_o), .ext_ready_i(ext_ready_i),
        .link_data_o(link_data_o), .link_v_o(link_v_o), .link_ready_i(link_ready_i),
        .link_data_i(link_data_i), .link_v_i(link_v_i), .link_ready_o(link_ready_o),
        .ret_data_o(ret_data_o), .ret_v_o(ret_v_o), .ret_ready_i(ret_ready_i),
        .ret_data_i(ret_data_i), .ret_v_i(ret_v_i), .ret_ready_o(ret_ready_o),
        .credits_o(credits_o), .error_o(error_o)
    );

    // ---- stub instance ----
    logic          s_reset_i;
    logic [X-1:0]  s_my_x_i;
    logic [Y-1:0]  s_my_y_i;
    logic [O-1:0]  s_ext_data_i, s_ext_data_o;
    logic          s_ext_v_i, s_ext_ready_o, s_ext_v_o, s_ext_ready_i;
    logic [PW-1:0] s_link_data_o, s_link_data_i;
    logic          s_link_v_o, s_link_ready_i, s_link_v_i, s_link_ready_o;
    logic [RW-1:0] s_ret_data_o, s_ret_data_i;
    logic          s_ret_v_o, s_ret_ready_i, s_ret_v_i, s_ret_ready_o;
    logic [CW-1:0] s_credits_o;
    logic          s_error_o;

    bsg_manycore_edge_bridge #(
        .x_cord_width_p(X), .y_cord_width_p(Y), .orig_packet_width_p(O),
        .in_fifo_els_p(2), .out_fifo_els_p(2), .ret_fifo_els_p(2),
        .max_credits_p(2), .stub_p(1)
    ) stub (
        .clk_i(clk), .reset_i(s_reset_i), .my_x_i(s_my_x_i), .my_y_i(s_my_y_i),
        .ext_data_i(s_ext_data_i), .ext_v_i(s_ext_v_i), .ext_ready_o(s_ext_ready_o),
        .ext_data_o(s_ext_data_o), .ext_v_o(s_ext_v_o), .ext_ready_i(s_ext_ready_i),
        .link_data_o(s_link_data_o), .link_v_o(s_link_v_o), .link_ready_i(s_link_ready_i),
        .link_data_i(s_link_data_i), .link_v_i(s_link_v_i), .link_ready_o(s_link_ready_o),
        .ret_data_o(s_ret_data_o), .ret_v_o(s_ret_v_o), .ret_ready_i(s_ret_ready_i),
        .ret_data_i(s_ret_data_i), .ret_v_i(s_ret_v_i), .ret_ready_o(s_ret_ready_o),
        .credits_o(s_credits_o), .error_o(s_error_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] mk(input logic [O-1:0] d, input logic [Y-1:0] y, input logic [X-1:0] x);
        return {d, y, x};
    endfunction

    logic [O-1:0] rx [3];
    int           got;
    bit           accepted;

    initial begin
        reset_i = 1'b1; my_x_i = 2'd1; my_y_i = 3'd2;
        ext_data_i = '0; ext_v_i = 0; ext_ready_i = 0;
        link_data_i = '0; link_v_i = 0; link_ready_i = 0;
        ret_data_i = '0; ret_v_i = 0; ret_ready_i = 0;
        s_reset_i = 1'b1; s_my_x_i = '0; s_my_y_i = '0; s_ext_data_i = '0; s_ext_v_i = 0;
        s_ext_ready_i = 0; s_link_data_i = '0; s_link_v_i = 0; s_link_ready_i = 0;
        s_ret_data_i = '0; s_ret_v_i = 0; s_ret_ready_i = 0;

        // ---- reset state ----
        step();
        chk("ret_ready_in_reset", ret_ready_o, 0);
        step();
        reset_i = 0;
        step();
        chk("rst_ext_v", ext_v_o, 0);
        chk("rst_link_v", link_v_o, 0);
        chk("rst_ret_v", ret_v_o, 0);
        chk("rst_ext_ready", ext_ready_o, 1);
        chk("rst_link_ready", link_ready_o, 1);
        chk("rst_ret_ready", ret_ready_o, 1);
        chk("rst_credits", credits_o, 0);
        chk("rst_error", error_o, 0);

        // ---- ingress: coordinates appended, 1-cycle latency ----
        ext_data_i = 16'hA5C3; ext_v_i = 1;
        step();
        ext_v_i = 0;
        chk("ing_link_v", link_v_o, 1);
        chk("ing_link_data", link_data_o, 21'h14B869);
        chk("ing_credits0", credits_o, 0);
        link_ready_i = 1;
        step();
        link_ready_i = 0;
        chk("ing_credits1", credits_o, 1);
        chk("ing_link_v_empty", link_v_o, 0);
        ret_data_i = 7'b0000001; ret_v_i = 1;
        step();
        ret_v_i = 0;
        chk("ing_ret_credits0", credits_o, 0);

        // ---- credit limit: 3 packets, only 2 forwarded ----
        link_ready_i = 1; ext_v_i = 1;
        ext_data_i = 16'h0001; step();
        ext_data_i = 16'h0002; step();
        ext_data_i = 16'h0003; step();
        ext_v_i = 0;
        step(); step();
        chk("lim_credits2", credits_o, 2);
        chk("lim_link_v_blocked", link_v_o, 0);
        chk("lim_held_data", link_data_o, mk(16'h0003, 3'd2, 2'd1));
        ret_v_i = 1; step(); ret_v_i = 0;
        chk("lim_unblock_credits", credits_o, 1);
        chk("lim_unblock_link_v", link_v_o, 1);
        step();
        chk("lim_third_sent", credits_o, 2);
        chk("lim_fifo_empty", link_v_o, 0);

        // ---- simultaneous increment and decrement ----
        link_ready_i = 0;
        ret_v_i = 1; step(); ret_v_i = 0;
        ext_data_i = 16'h0004; ext_v_i = 1; step(); ext_v_i = 0;
        chk("sim_pre_credits", credits_o, 1);
        link_ready_i = 1; ret_v_i = 1; step();
        link_ready_i = 0;
        chk("sim_credits_same", credits_o, 1);
        chk("sim_no_error", error_o, 0);
        step(); ret_v_i = 0;
        chk("sim_drained", credits_o, 0);

        // ---- errors ----
        ret_v_i = 1; step(); ret_v_i = 0;
        chk("err_underflow", error_o, 1);
        chk("err_underflow_credits", credits_o, 0);
        step(); step();
        chk("err_sticky", error_o, 1);
        reset_i = 1; step(); reset_i = 0; step();
        chk("err_cleared", error_o, 0);
        ext_data_i = 16'h0005; ext_v_i = 1; link_ready_i = 1; step(); ext_v_i = 0;
        step(); link_ready_i = 0;
        chk("err_type_pre", credits_o, 1);
        ret_data_i = 7'b0000010; ret_v_i = 1; step(); ret_v_i = 0;
        chk("err_bad_type", error_o, 1);
        reset_i = 1; step(); reset_i = 0; step();

        // ---- egress + returns ----
        ext_ready_i = 1; ret_ready_i = 0;
        link_data_i = mk(16'h1234, 3'd3, 2'd2); link_v_i = 1; step(); link_v_i = 0;
        chk("egr_ext_v", ext_v_o, 1);
        chk("egr_ext_data", ext_data_o, 16'h1234);
        step();
        chk("egr_ret_v", ret_v_o, 1);
        chk("egr_ret_data", ret_data_o, 7'h39);
        link_data_i = mk(16'h5678, 3'd1, 2'd0); link_v_i = 1; step(); link_v_i = 0;
        step();
        link_data_i = mk(16'h9ABC, 3'd2, 2'd3); link_v_i = 1; step(); link_v_i = 0;
        chk("egr_blocked_ret_full", ext_v_o, 0);
        step();
        chk("egr_still_blocked", ext_v_o, 0);
        chk("egr_ret_head", ret_data_o, 7'h39);
        ret_ready_i = 1; step();
        chk("egr_unblocked", ext_v_o, 1);
        chk("egr_ret_second", ret_data_o, 7'h11);
        chk("egr_third_data", ext_data_o, 16'h9ABC);
        step();
        chk("egr_ret_third", ret_data_o, 7'h2D);
        step();
        chk("egr_ret_empty", ret_v_o, 0);
        chk("egr_ext_empty", ext_v_o, 0);

        // ---- egress backpressure, then release in order ----
        ext_ready_i = 0;
        link_v_i = 1;
        link_data_i = mk(16'hD000, 3'd0, 2'd0); step();
        link_data_i = mk(16'hD001, 3'd1, 2'd1); step();
        chk("bp_ready_low", link_ready_o, 0);
        link_data_i = mk(16'hD002, 3'd2, 2'd2); step();
        chk("bp_ready_still_low", link_ready_o, 0);
        ext_ready_i = 1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (ext_v_o) begin
                rx[got] = ext_data_o;
                got++;
            end
            accepted = link_v_i && link_ready_o;
            step();
            if (accepted) link_v_i = 0;
        end
        chk("bp_count", got, 3);
        chk("bp_order0", rx[0], 16'hD000);
        chk("bp_order1", rx[1], 16'hD001);
        chk("bp_order2", rx[2], 16'hD002);
        step(); step(); step();

        // ---- reset mid-stream with 2 entries in each FIFO ----
        ret_ready_i = 0; ext_ready_i = 1; link_v_i = 1;
        link_data_i = mk(16'hE000, 3'd0, 2'd1); step();
        link_data_i = mk(16'hE001, 3'd0, 2'd2); step();
        link_v_i = 0; step();
        ext_ready_i = 0; link_v_i = 1;
        link_data_i = mk(16'hE002, 3'd0, 2'd3); step();
        link_data_i = mk(16'hE003, 3'd1, 2'd0); step();
        link_v_i = 0;
        link_ready_i = 0; ext_v_i = 1;
        ext_data_i = 16'hF000; step();
        ext_data_i = 16'hF001; step();
        ext_v_i = 0;
        chk("mid_pre_full", {ret_v_o, link_v_o, link_ready_o, ext_ready_o}, 4'b1100);
        reset_i = 1; step(); reset_i = 0;
        chk("mid_valids_zero", {ext_v_o, link_v_o, ret_v_o}, 3'b000);
        chk("mid_credits_zero", credits_o, 0);
        ext_ready_i = 1; ret_ready_i = 1; link_ready_i = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_no_stale", {ext_v_o, link_v_o, ret_v_o, credits_o}, 5'b0);
        end
        link_ready_i = 0;

        // ---- stub mode: random stimulus, outputs always 0 ----
        for (int c = 0; c < 20; c++) begin
            s_reset_i      = 1'($urandom_range(0, 1));
            s_my_x_i       = X'($urandom);
            s_my_y_i       = Y'($urandom);
            s_ext_data_i   = O'($urandom);
            s_ext_v_i      = 1'($urandom);
            s_ext_ready_i  = 1'($urandom);
            s_link_data_i  = PW'($urandom);
            s_link_v_i     = 1'($urandom);
            s_link_ready_i = 1'($urandom);
            s_ret_data_i   = RW'($urandom);
            s_ret_v_i      = 1'($urandom);
            s_ret_ready_i  = 1'($urandom);
            step();
            chk("stub_outputs", {31'd0, |{s_ext_ready_o, s_ext_data_o, s_ext_v_o, s_link_data_o, s_link_v_o,
                                        s_link_ready_o, s_ret_data_o, s_ret_v_o, s_ret_ready_o,
                                        s_credits_o, s_error_o}}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
